pll_lock_sequencer: RTL
=======================

// Module: pll_lock_sequencer
// PURPOSE
//   Reset and lock controller for the 2-output fabric PLL (refclk in, outclk_0/outclk_1, locked).
//   Drives the PLL reset, qualifies 'locked', and releases the downstream system reset only after
//   lock has been stable. It retries on lock timeout and re-sequences on lock loss.
//   Runs in the refclk domain, between board reset and every block clocked by the PLL outputs.
// PARAMETERS
//   RST_CYCLES    16      refclk cycles pll_rst is held high per reset attempt (>=2)
//   LOCK_TIMEOUT  65536   refclk cycles to wait for lock before retrying (>=4)
//   STABLE_CYCLES 1024    consecutive synchronized-locked cycles required before release (>=1)
//   MAX_RETRIES   3       timeout retries before declaring FAIL (>=1)
//   (local) RETRY_W = $clog2(MAX_RETRIES+1); CNT_W sized to the largest of the three cycle counts
// PORTS
//   refclk      in   1        reference clock; the only clock in the block
//   rst         in   1        synchronous active-high reset
//   locked      in   1        PLL lock, asynchronous to refclk
//   relock_req  in   1        1-cycle pulse: restart the full sequence, clear retry count
//   clr_status  in   1        1-cycle pulse: clear sticky lock_lost
//   pll_rst     out  1        reset to PLL
//   sys_rst     out  1        reset to downstream logic; high until lock is qualified
//   ready       out  1        high exactly when state==RUN
//   fail        out  1        high exactly when state==FAIL
//   lock_lost   out  1        sticky: lock dropped while in RUN
//   retry_cnt   out  RETRY_W  timeout retries used in current sequence
//   state_o     out  3        state encoding: 0 RST_HOLD, 1 WAIT_LOCK, 2 STABLE, 3 RUN, 4 FAIL
// BEHAVIOUR
//   - locked passes a 2-flop synchronizer (reset 0) -> locked_s; 2-edge latency.
//   - Reset (rst=1 at edge): state=RST_HOLD, cnt=0, retry_cnt=0, lock_lost=0, sync flops=0.
//     Outputs after reset: pll_rst=1, sys_rst=1, ready=0, fail=0.
//   - Outputs are pure decode of the state register:
//     pll_rst=(RST_HOLD|FAIL); sys_rst=!RUN; ready=RUN; fail=FAIL.
//   - Priority per edge: rst > relock_req > state transitions below.
//   - relock_req in any state: ->RST_HOLD, cnt=0, retry_cnt=0.
//   - RST_HOLD: cnt++; at cnt==RST_CYCLES-1 ->WAIT_LOCK, cnt=0 (pll_rst high exactly RST_CYCLES cycles).
//   - WAIT_LOCK: if locked_s ->STABLE, cnt=0.
//     Else at cnt==LOCK_TIMEOUT-1: if retry_cnt==MAX_RETRIES ->FAIL;
//     otherwise retry_cnt++, ->RST_HOLD, cnt=0. Else cnt++.
//   - STABLE: if !locked_s ->WAIT_LOCK, cnt=0 (timeout restarts, retry_cnt kept).
//     Else at cnt==STABLE_CYCLES-1 ->RUN. Else cnt++.
//   - RUN: cnt held 0. If !locked_s: lock_lost=1, retry_cnt=0, ->RST_HOLD.
//     sys_rst rises on the same edge as the transition.
//   - FAIL: terminal; pll_rst held high; only rst or relock_req exits.
//   - lock_lost: set by the RUN lock-loss event, cleared by clr_status. Set wins on the same edge.
//   - Counters never wrap: cnt is cleared on every state change; retry_cnt <= MAX_RETRIES always.
//   - Any state encoding outside 0-4 ->RST_HOLD on the next edge.
// TESTING (bench params: RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2)
//   1 Nominal: release rst, raise locked 10 cycles after pll_rst falls.
//     -> pll_rst high 4 cycles; sys_rst falls/ready rises on the 11th edge after locked first
//        sampled high; fail=0; retry_cnt=0.
//   2 Glitch in STABLE: drop locked 3 cycles at stable cnt=5.
//     -> state_o returns to 1, sys_rst stays 1; after relock, full 8 stable cycles needed again.
//   3 Never lock: hold locked=0.
//     -> 3 pll_rst pulses of 4 cycles, each 32 WAIT_LOCK cycles apart; retry_cnt 0->1->2;
//        then fail=1, state_o=4, pll_rst=1 held.
//   4 Loss in RUN: drop locked.
//     -> sys_rst=1 and lock_lost=1 on the 3rd edge; 4-cycle pll_rst pulse; relock ->ready=1;
//        lock_lost stays 1 until clr_status.
//   5 Simultaneous: clr_status on the lock-loss edge -> lock_lost=1.
//     relock_req while in FAIL -> state_o=0 next edge, retry_cnt=0, fail=0.
//   6 rst asserted mid-STABLE and mid-RUN -> next edge: state_o=0, pll_rst=1, sys_rst=1,
//     ready=0, lock_lost=0, retry_cnt=0.

Source files
------------

// File: rtl/pll_lock_sequencer_if.sv
// Control/status bundle between the PLL lock sequencer and its environment.
// Latency: none, wires only.
// Backpressure: none; level and pulse signals only.
interface pll_lock_sequencer_if #(
    parameter int RETRY_W = 2
);
    logic               locked;
    logic               relock_req;
    logic               clr_status;
    logic               pll_rst;
    logic               sys_rst;
    logic               ready;
    logic               fail;
    logic               lock_lost;
    logic [RETRY_W-1:0] retry_cnt;
    logic [2:0]         state_o;

    // Environment side: drives lock and requests, observes resets and status.
    modport master (
        output locked, relock_req, clr_status,
        input  pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt, state_o
    );

    // Sequencer side.
    modport slave (
        input  locked, relock_req, clr_status,
        output pll_rst, sys_rst, ready, fail, lock_lost, retry_cnt, state_o
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Sequences PLL reset, qualifies synchronized lock, then releases the system reset.
// Latency: locked reaches the FSM after 2 refclk edges; outputs decode the state register.
// Backpressure: none; relock_req and clr_status are single-cycle pulses.
module pll_lock_sequencer #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 65536,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3
) (
    input  logic                  refclk,
    input  logic                  rst,
    pll_lock_sequencer_if.slave   bus
);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int CNT_MAX = (RST_CYCLES > LOCK_TIMEOUT)
                           ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
                           : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
    // Counter only has to reach CNT_MAX-1, so clog2 of the largest count is enough.
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [2:0] {
        ST_RST_HOLD  = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [RETRY_W-1:0] retry_q;
    logic               lost_q;
    logic               sync1_q;
    logic               locked_s_q;

    // Two-flop synchronizer bringing the asynchronous lock indication into refclk.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync1_q    <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            sync1_q    <= bus.locked;
            locked_s_q <= sync1_q;
        end
    end

    // Sequencer FSM with its cycle counter, retry count and sticky lock-loss flag.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q <= ST_RST_HOLD;
            cnt_q   <= '0;
            retry_q <= '0;
            lost_q  <= 1'b0;
        end else begin
            // Clear first so a lock-loss set later in this block wins the same edge.
            if (bus.clr_status) begin
                lost_q <= 1'b0;
            end
            if (bus.relock_req) begin
                state_q <= ST_RST_HOLD;
                cnt_q   <= '0;
                retry_q <= '0;
            end else begin
                case (state_q)
                    ST_RST_HOLD: begin
                        if (cnt_q == CNT_W'(RST_CYCLES - 1)) begin
                            state_q <= ST_WAIT_LOCK;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_WAIT_LOCK: begin
                        if (locked_s_q) begin
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
                            cnt_q <= '0;
                            if (retry_q == RETRY_W'(MAX_RETRIES)) begin
                                state_q <= ST_FAIL;
                            end else begin
                                retry_q <= retry_q + RETRY_W'(1);
                                state_q <= ST_RST_HOLD;
                            end
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_STABLE: begin
                        // A dropout restarts the lock wait but keeps the retries already spent.
                        if (!locked_s_q) begin
                            state_q <= ST_WAIT_LOCK;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_W'(STABLE_CYCLES - 1)) begin
                            state_q <= ST_RUN;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    ST_RUN: begin
                        cnt_q <= '0;
                        if (!locked_s_q) begin
                            lost_q  <= 1'b1;
                            retry_q <= '0;
                            state_q <= ST_RST_HOLD;
                        end
                    end
                    ST_FAIL: begin
                        cnt_q <= '0;
                    end
                    default: begin
                        state_q <= ST_RST_HOLD;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign bus.pll_rst   = (state_q == ST_RST_HOLD) || (state_q == ST_FAIL);
    assign bus.sys_rst   = (state_q != ST_RUN);
    assign bus.ready     = (state_q == ST_RUN);
    assign bus.fail      = (state_q == ST_FAIL);
    assign bus.lock_lost = lost_q;
    assign bus.retry_cnt = retry_q;
    assign bus.state_o   = state_q;
endmodule
